// File: rtl/i2c_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2c_seq_pkg
// Description : Shared types and constants for the I2C transfer sequencer:
//               FSM state encoding, request-length width helper and default
//               divider / timeout values.
// Revision    : 1.0 - initial release
// ============================================================================
package i2c_seq_pkg;

    // Sequencer states; explicit 4-bit encoding
    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_START     = 4'd1,
        ST_ADDR      = 4'd2,
        ST_TX_LOAD   = 4'd3,
        ST_TX_WAIT   = 4'd4,
        ST_RX_WAIT   = 4'd5,
        ST_STOP      = 4'd6,
        ST_STOP_WAIT = 4'd7,
        ST_FIN       = 4'd8
    } seq_state_e;

    localparam logic [7:0]  CNT_SET_DEFAULT = 8'hFA;
    localparam logic [15:0] TIMEOUT_DEFAULT = 16'd50000;
    localparam logic [6:0]  ADR_RESET       = 7'h5A;

    // Bits needed to hold a byte count of 0..max_len
    function automatic int len_width(input int max_len);
        return (max_len < 1) ? 1 : $clog2(max_len + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_seq_timer.sv
`default_nettype none
// ============================================================================
// Module      : i2c_seq_timer
// Description : Clearable 16-bit saturating cycle counter. 'hit' flags the
//               LIMIT-th enabled cycle since the last clear.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_seq_timer
    import i2c_seq_pkg::*;
#(
    parameter logic [15:0] LIMIT = TIMEOUT_DEFAULT
) (
    input  logic HCLK,
    input  logic HRESETn,
    input  logic clr,
    input  logic en,
    output logic hit
);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    // Next count: clear wins, otherwise count up and stick at all-ones
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Counter register with synchronous active-low reset
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Count starts at 0 in the first cycle, so LIMIT-1 marks the LIMIT-th cycle
    assign hit = en && (cnt_q >= (LIMIT - 16'd1));

endmodule
`default_nettype wire

// File: rtl/i2c_xfer_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : i2c_xfer_sequencer
// Description : Runs a complete I2C master transfer (start, address, N data
//               bytes, stop) against the I2C core strobes, streams write bytes
//               in and read bytes out, and reports done / NACK / timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_xfer_sequencer
    import i2c_seq_pkg::*;
#(
    parameter  int          MAX_LEN = 8,
    parameter  logic [7:0]  CNT_SET = CNT_SET_DEFAULT,
    parameter  logic [15:0] TIMEOUT = TIMEOUT_DEFAULT,
    localparam int          LW      = len_width(MAX_LEN)
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    // request channel
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_rd,
    input  logic [6:0]    req_addr,
    input  logic [LW-1:0] req_len,
    // write data stream
    input  logic          wdata_valid,
    input  logic [7:0]    wdata,
    output logic          wdata_ready,
    // read data stream
    output logic          rdata_valid,
    output logic [7:0]    rdata,
    // completion
    output logic          done,
    output logic          err_nack,
    output logic          err_tmo,
    output logic          busy,
    // core control
    output logic          i2c_start,
    output logic          i2c_stop,
    output logic [6:0]    i2c_adr_r,
    output logic          i2c_wr_r,
    output logic [7:0]    cnt_set,
    output logic          tx_en,
    output logic [7:0]    tx_data,
    // core status
    input  logic          sigbyte_finishf,
    input  logic          i2c_nackf_set,
    input  logic          i2c_rxbf_set,
    input  logic [7:0]    rx_buf,
    input  logic          stop_f
);

    localparam logic [LW-1:0] MAX_LEN_W = LW'(MAX_LEN);

    seq_state_e    state_q, state_d;
    logic [6:0]    addr_q, addr_d;
    logic          rd_q, rd_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] byte_cnt_q, byte_cnt_d;
    logic [LW-1:0] byte_cnt_inc;
    logic          nack_flag_q, nack_flag_d;
    logic          tmo_flag_q, tmo_flag_d;
    logic          nack_pend_q, nack_pend_d;
    logic          fin_q, fin_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic [7:0]    rdata_q, rdata_d;
    logic          tx_en_q, tx_en_d;
    logic          wdata_ready_q, wdata_ready_d;
    logic          rdata_valid_q, rdata_valid_d;
    logic          req_ready_q, req_ready_d;
    logic          busy_q, busy_d;
    logic          i2c_start_q, i2c_start_d;
    logic          i2c_stop_q, i2c_stop_d;
    logic          done_q, done_d;
    logic          err_nack_q, err_nack_d;
    logic          err_tmo_q, err_tmo_d;

    logic          fin_rise;
    logic          nack_now;
    logic          tmo_hit;
    logic          timer_clr;
    logic          timer_en;

    // Byte-complete is a level from the core; only its rising edge counts
    assign fin_d    = sigbyte_finishf;
    assign fin_rise = sigbyte_finishf & ~fin_q;

    // A NACK pulse may land a little before the byte-complete edge, so it is held
    assign nack_now = i2c_nackf_set | nack_pend_q;

    assign byte_cnt_inc = byte_cnt_q + LW'(1);

    // Per-state timeout: restarts on every state change, runs only in wait states
    assign timer_clr = (state_d != state_q);
    assign timer_en  = (state_q == ST_ADDR)    || (state_q == ST_TX_LOAD) ||
                       (state_q == ST_TX_WAIT) || (state_q == ST_RX_WAIT) ||
                       (state_q == ST_STOP_WAIT);

    i2c_seq_timer #(
        .LIMIT   (TIMEOUT)
    ) u_timer (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .clr     (timer_clr),
        .en      (timer_en),
        .hit     (tmo_hit)
    );

    // Next-state, datapath and registered-output computation
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        rd_d          = rd_q;
        len_d         = len_q;
        byte_cnt_d    = byte_cnt_q;
        nack_flag_d   = nack_flag_q;
        tmo_flag_d    = tmo_flag_q;
        nack_pend_d   = nack_pend_q;
        tx_data_d     = tx_data_q;
        rdata_d       = rdata_q;
        tx_en_d       = 1'b0;
        wdata_ready_d = 1'b0;
        rdata_valid_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d      = req_addr;
                    rd_d        = req_rd;
                    len_d       = (req_len > MAX_LEN_W) ? MAX_LEN_W : req_len;
                    byte_cnt_d  = '0;
                    nack_flag_d = 1'b0;
                    tmo_flag_d  = 1'b0;
                    state_d     = ST_START;
                end
            end
            ST_START: begin
                state_d = ST_ADDR;
            end
            ST_ADDR: begin
                if (fin_rise) begin
                    if (nack_now) begin
                        nack_flag_d = 1'b1;
                        state_d     = ST_STOP;
                    end else if (len_q == '0) begin
                        state_d = ST_STOP;
                    end else if (rd_q) begin
                        state_d = ST_RX_WAIT;
                    end else begin
                        state_d = ST_TX_LOAD;
                    end
                end else if (tmo_hit) begin
                    tmo_flag_d = 1'b1;
                    state_d    = ST_STOP;
                end
            end
            ST_TX_LOAD: begin
                if (wdata_valid) begin
                    wdata_ready_d = 1'b1;
                    tx_en_d       = 1'b1;
                    tx_data_d     = wdata;
                    state_d       = ST_TX_WAIT;
                end else if (tmo_hit) begin
                    tmo_flag_d = 1'b1;
                    state_d    = ST_STOP;
                end
            end
            ST_TX_WAIT: begin
                if (fin_rise) begin
                    // The byte went out either way, so count it before judging the ACK
                    byte_cnt_d = byte_cnt_inc;
                    if (nack_now) begin
                        nack_flag_d = 1'b1;
                        state_d     = ST_STOP;
                    end else if (byte_cnt_inc == len_q) begin
                        state_d = ST_STOP;
                    end else begin
                        state_d = ST_TX_LOAD;
                    end
                end else if (tmo_hit) begin
                    tmo_flag_d = 1'b1;
                    state_d    = ST_STOP;
                end
            end
            ST_RX_WAIT: begin
                if (i2c_rxbf_set) begin
                    rdata_valid_d = 1'b1;
                    rdata_d       = rx_buf;
                    byte_cnt_d    = byte_cnt_inc;
                    if (byte_cnt_inc == len_q) begin
                        state_d = ST_STOP;
                    end
                end else if (tmo_hit) begin
                    tmo_flag_d = 1'b1;
                    state_d    = ST_STOP;
                end
            end
            ST_STOP: begin
                state_d = ST_STOP_WAIT;
            end
            ST_STOP_WAIT: begin
                if (stop_f) begin
                    state_d = ST_FIN;
                end else if (tmo_hit) begin
                    tmo_flag_d = 1'b1;
                    state_d    = ST_FIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Pending NACK lives only within the ADDR / TX_WAIT state that saw it
        if (state_d != state_q) begin
            nack_pend_d = 1'b0;
        end else if (i2c_nackf_set &&
                     ((state_q == ST_ADDR) || (state_q == ST_TX_WAIT))) begin
            nack_pend_d = 1'b1;
        end

        // Outputs are registered views of the state being entered
        req_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
        i2c_start_d = (state_d == ST_START);
        i2c_stop_d  = (state_d == ST_STOP) || (state_d == ST_STOP_WAIT);
        done_d      = (state_d == ST_FIN);
        err_nack_d  = (state_d == ST_FIN) && nack_flag_d;
        err_tmo_d   = (state_d == ST_FIN) && tmo_flag_d;
    end

    // Sequencer state and registered outputs, synchronous active-low reset
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q       <= ST_IDLE;
            addr_q        <= ADR_RESET;
            rd_q          <= 1'b1;
            len_q         <= '0;
            byte_cnt_q    <= '0;
            nack_flag_q   <= 1'b0;
            tmo_flag_q    <= 1'b0;
            nack_pend_q   <= 1'b0;
            fin_q         <= 1'b0;
            tx_data_q     <= '0;
            rdata_q       <= '0;
            tx_en_q       <= 1'b0;
            wdata_ready_q <= 1'b0;
            rdata_valid_q <= 1'b0;
            req_ready_q   <= 1'b1;
            busy_q        <= 1'b0;
            i2c_start_q   <= 1'b0;
            i2c_stop_q    <= 1'b0;
            done_q        <= 1'b0;
            err_nack_q    <= 1'b0;
            err_tmo_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            rd_q          <= rd_d;
            len_q         <= len_d;
            byte_cnt_q    <= byte_cnt_d;
            nack_flag_q   <= nack_flag_d;
            tmo_flag_q    <= tmo_flag_d;
            nack_pend_q   <= nack_pend_d;
            fin_q         <= fin_d;
            tx_data_q     <= tx_data_d;
            rdata_q       <= rdata_d;
            tx_en_q       <= tx_en_d;
            wdata_ready_q <= wdata_ready_d;
            rdata_valid_q <= rdata_valid_d;
            req_ready_q   <= req_ready_d;
            busy_q        <= busy_d;
            i2c_start_q   <= i2c_start_d;
            i2c_stop_q    <= i2c_stop_d;
            done_q        <= done_d;
            err_nack_q    <= err_nack_d;
            err_tmo_q     <= err_tmo_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign busy        = busy_q;
    assign wdata_ready = wdata_ready_q;
    assign rdata_valid = rdata_valid_q;
    assign rdata       = rdata_q;
    assign done        = done_q;
    assign err_nack    = err_nack_q;
    assign err_tmo     = err_tmo_q;
    assign i2c_start   = i2c_start_q;
    assign i2c_stop    = i2c_stop_q;
    assign i2c_adr_r   = addr_q;
    assign i2c_wr_r    = rd_q;
    assign cnt_set     = CNT_SET;
    assign tx_en       = tx_en_q;
    assign tx_data     = tx_data_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_xfer_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_xfer_sequencer
// Description : Directed self-checking bench for i2c_xfer_sequencer with a
//               cycle-stepped I2C core model driven from the main process.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_xfer_sequencer;

    logic       HCLK;
    logic       HRESETn;
    logic       req_valid;
    logic       req_ready;
    logic       req_rd;
    logic [6:0] req_addr;
    logic [3:0] req_len;
    logic       wdata_valid;
    logic [7:0] wdata;
    logic       wdata_ready;
    logic       rdata_valid;
    logic [7:0] rdata;
    logic       done;
    logic       err_nack;
    logic       err_tmo;
    logic       busy;
    logic       i2c_start;
    logic       i2c_stop;
    logic [6:0] i2c_adr_r;
    logic       i2c_wr_r;
    logic [7:0] cnt_set;
    logic       tx_en;
    logic [7:0] tx_data;
    logic       sigbyte_finishf;
    logic       i2c_nackf_set;
    logic       i2c_rxbf_set;
    logic [7:0] rx_buf;
    logic       stop_f;

    int n_tests = 0;
    int n_fail  = 0;

    // pulse logs filled by the monitor
    int         tx_cnt = 0;
    int         rd_cnt = 0;
    logic [7:0] tx_log [16];
    logic [7:0] rd_log [16];

    i2c_xfer_sequencer #(
        .MAX_LEN (8),
        .CNT_SET (8'hFA),
        .TIMEOUT (16'd100)
    ) dut (
        .HCLK            (HCLK),
        .HRESETn         (HRESETn),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_rd          (req_rd),
        .req_addr        (req_addr),
        .req_len         (req_len),
        .wdata_valid     (wdata_valid),
        .wdata           (wdata),
        .wdata_ready     (wdata_ready),
        .rdata_valid     (rdata_valid),
        .rdata           (rdata),
        .done            (done),
        .err_nack        (err_nack),
        .err_tmo         (err_tmo),
        .busy            (busy),
        .i2c_start       (i2c_start),
        .i2c_stop        (i2c_stop),
        .i2c_adr_r       (i2c_adr_r),
        .i2c_wr_r        (i2c_wr_r),
        .cnt_set         (cnt_set),
        .tx_en           (tx_en),
        .tx_data         (tx_data),
        .sigbyte_finishf (sigbyte_finishf),
        .i2c_nackf_set   (i2c_nackf_set),
        .i2c_rxbf_set    (i2c_rxbf_set),
        .rx_buf          (rx_buf),
        .stop_f          (stop_f)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // Record tx / rx pulses mid-cycle, away from the active edge
    always @(negedge HCLK) begin
        if (tx_en) begin
            if (tx_cnt < 16) tx_log[tx_cnt] = tx_data;
            tx_cnt = tx_cnt + 1;
        end
        if (rdata_valid) begin
            if (rd_cnt < 16) rd_log[rd_cnt] = rdata;
            rd_cnt = rd_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests = n_tests + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge HCLK);
        #1;
    endtask

    task automatic clear_logs();
        tx_cnt = 0;
        rd_cnt = 0;
    endtask

    // Issue one request and confirm the start pulse that follows it
    task automatic request(input logic rd, input logic [6:0] addr, input logic [3:0] len, input string tag);
        req_valid = 1'b1;
        req_rd    = rd;
        req_addr  = addr;
        req_len   = len;
        cyc();
        req_valid = 1'b0;
        check({tag, "_start"}, {31'd0, i2c_start}, 32'd1);
        check({tag, "_adr"}, {25'd0, i2c_adr_r}, {25'd0, addr});
        cyc();
        check({tag, "_start_1cyc"}, {31'd0, i2c_start}, 32'd0);
    endtask

    // Core model: byte-complete flag high for two cycles, optional NACK pulse
    task automatic core_byte_done(input logic nack);
        sigbyte_finishf = 1'b1;
        i2c_nackf_set   = nack;
        cyc();
        i2c_nackf_set   = 1'b0;
        cyc();
        sigbyte_finishf = 1'b0;
        cyc();
    endtask

    task automatic send_byte(input logic [7:0] d, input string tag);
        bit seen = 1'b0;
        wdata_valid = 1'b1;
        wdata       = d;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (wdata_ready) begin
                seen = 1'b1;
                break;
            end
        end
        wdata_valid = 1'b0;
        if (!seen) check({tag, "_wready_seen"}, 32'd0, 32'd1);
    endtask

    task automatic core_rx(input logic [7:0] d);
        rx_buf       = d;
        i2c_rxbf_set = 1'b1;
        cyc();
        i2c_rxbf_set = 1'b0;
        cyc();
    endtask

    // Wait for stop, hold it, complete it, and check the done pulse and flags
    task automatic finish_stop(input string tag, input logic exp_nack, input logic exp_tmo);
        bit seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (i2c_stop) begin
                seen = 1'b1;
                break;
            end
            cyc();
        end
        check({tag, "_stop_seen"}, {31'd0, seen}, 32'd1);
        cyc();
        cyc();
        check({tag, "_stop_held"}, {30'd0, i2c_stop, done}, 32'b10);
        stop_f = 1'b1;
        cyc();
        stop_f = 1'b0;
        check({tag, "_done"}, {29'd0, done, err_nack, err_tmo}, {29'd0, 1'b1, exp_nack, exp_tmo});
        check({tag, "_stop_clr"}, {31'd0, i2c_stop}, 32'd0);
        cyc();
        check({tag, "_idle"}, {30'd0, req_ready, done}, 32'b10);
    endtask

    initial begin
        int n;
        HRESETn         = 1'b0;
        req_valid       = 1'b0;
        req_rd          = 1'b0;
        req_addr        = 7'h00;
        req_len         = 4'd0;
        wdata_valid     = 1'b0;
        wdata           = 8'h00;
        sigbyte_finishf = 1'b0;
        i2c_nackf_set   = 1'b0;
        i2c_rxbf_set    = 1'b0;
        rx_buf          = 8'h00;
        stop_f          = 1'b0;
        repeat (3) cyc();
        HRESETn = 1'b1;
        cyc();

        // ---- reset state
        check("rst_ready",   {31'd0, req_ready}, 32'd1);
        check("rst_busy",    {31'd0, busy}, 32'd0);
        check("rst_adr",     {25'd0, i2c_adr_r}, 32'h5A);
        check("rst_wr",      {31'd0, i2c_wr_r}, 32'd1);
        check("rst_cnt_set", {24'd0, cnt_set}, 32'hFA);
        check("rst_strobes", {26'd0, i2c_start, i2c_stop, tx_en, done, err_nack, err_tmo}, 32'd0);

        // ---- write 2 bytes, all ACKed
        clear_logs();
        request(1'b0, 7'h50, 4'd2, "wr");
        check("wr_dir", {30'd0, i2c_wr_r, req_ready}, 32'b00);
        core_byte_done(1'b0);
        send_byte(8'hA5, "wr_b0");
        core_byte_done(1'b0);
        send_byte(8'h3C, "wr_b1");
        core_byte_done(1'b0);
        // a request while busy must be ignored
        req_valid = 1'b1;
        req_addr  = 7'h11;
        cyc();
        req_valid = 1'b0;
        check("wr_busy_ignore", {25'd0, i2c_adr_r}, 32'h50);
        finish_stop("wr", 1'b0, 1'b0);
        check("wr_tx_cnt", tx_cnt, 32'd2);
        check("wr_tx0", {24'd0, tx_log[0]}, 32'hA5);
        check("wr_tx1", {24'd0, tx_log[1]}, 32'h3C);

        // ---- read 3 bytes
        clear_logs();
        request(1'b1, 7'h5A, 4'd3, "rd");
        core_byte_done(1'b0);
        core_rx(8'h11);
        core_rx(8'h22);
        core_rx(8'h33);
        check("rd_wr_r", {31'd0, i2c_wr_r}, 32'd1);
        finish_stop("rd", 1'b0, 1'b0);
        check("rd_cnt", rd_cnt, 32'd3);
        check("rd_bytes", {8'd0, rd_log[0], rd_log[1], rd_log[2]}, 32'h00112233);
        check("rd_no_tx", tx_cnt, 32'd0);

        // ---- read with oversized length, clamped to 8
        clear_logs();
        request(1'b1, 7'h21, 4'd15, "clamp");
        core_byte_done(1'b0);
        for (int i = 0; i < 7; i++) core_rx(8'(8'h40 + i));
        check("clamp_no_stop_7", {31'd0, i2c_stop}, 32'd0);
        rx_buf       = 8'h47;
        i2c_rxbf_set = 1'b1;
        cyc();
        i2c_rxbf_set = 1'b0;
        check("clamp_stop_8", {31'd0, i2c_stop}, 32'd1);
        finish_stop("clamp", 1'b0, 1'b0);
        check("clamp_cnt", rd_cnt, 32'd8);

        // ---- address-only probe, NACKed
        clear_logs();
        request(1'b0, 7'h33, 4'd0, "probe");
        core_byte_done(1'b1);
        finish_stop("probe", 1'b1, 1'b0);
        check("probe_no_data", tx_cnt + rd_cnt, 32'd0);

        // ---- write 4 bytes, NACK on the second
        clear_logs();
        request(1'b0, 7'h50, 4'd4, "nack");
        core_byte_done(1'b0);
        send_byte(8'h01, "nack_b0");
        core_byte_done(1'b0);
        send_byte(8'h02, "nack_b1");
        core_byte_done(1'b1);
        finish_stop("nack", 1'b1, 1'b0);
        check("nack_tx_cnt", tx_cnt, 32'd2);

        // ---- timeout in TX_LOAD: stop appears after the 100th cycle there
        clear_logs();
        request(1'b0, 7'h50, 4'd1, "tmo");
        sigbyte_finishf = 1'b1;
        cyc();
        sigbyte_finishf = 1'b0;
        n = 0;
        for (int i = 0; i < 200; i++) begin
            cyc();
            n = n + 1;
            if (i2c_stop) break;
        end
        check("tmo_cycles", n, 32'd100);
        finish_stop("tmo", 1'b0, 1'b1);
        check("tmo_no_tx", tx_cnt, 32'd0);

        // ---- reset during TX_WAIT, then a clean transfer
        clear_logs();
        request(1'b0, 7'h50, 4'd2, "rst");
        core_byte_done(1'b0);
        send_byte(8'h77, "rst_b0");
        HRESETn = 1'b0;
        cyc();
        HRESETn = 1'b1;
        check("midrst_state", {29'd0, req_ready, busy, i2c_stop}, 32'b100);
        check("midrst_adr", {25'd0, i2c_adr_r}, 32'h5A);
        clear_logs();
        request(1'b0, 7'h22, 4'd1, "post");
        core_byte_done(1'b0);
        send_byte(8'h9E, "post_b0");
        core_byte_done(1'b0);
        finish_stop("post", 1'b0, 1'b0);
        check("post_tx", {tx_cnt[23:0], tx_log[0]}, 32'h0000019E);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute guard so the bench always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
